fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and load-use hazard controller for the pipelined LEGv8 datapath. It replaces the fixed two-source, two-stage combinational forwarding logic. It looks at the instruction in ID and keeps its own shift-register scoreboard of the destinations of older in-flight instructions. From that it produces registered per-operand bypass selects for the EX stage and a load-use stall request for the fetch/decode control.

---
 rtl/fwd_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for a pipelined LEGv8 datapath.
//   A DEPTH-entry shift-register scoreboard tracks the destinations of
//   older in-flight instructions. Entry 0 is the instruction in EX, and
//   entry j is j stages older. The instruction in ID is compared against
//   every entry. The result is a registered per-source bypass select,
//   which is valid while that instruction sits in EX, plus a combinational
//   load-use stall request.
//
// Optional feature macro: FWD_STATS_EN (adds fwd_count / stall_count).
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high
//   hold         global freeze, all state holds
//   flush        squash the instruction in ID
//   id_valid     ID holds a real instruction
//   id_rd        ID destination register
//   id_regwrite  ID instruction writes id_rd
//   id_is_load   ID instruction is a load
//   id_src       NSRC packed source indices, source i at [i*REGW +: REGW]
//   id_src_used  per-source read enable
//   stall        combinational load-use stall request
//   fwd_sel      registered selects, source i at [i*SELW +: SELW];
//                0 = register file, k = pipeline register k
//   fwd_count    (FWD_STATS_EN) cycles that issued with any forwarding
//   stall_count  (FWD_STATS_EN) cycles with stall asserted
module fwd_hazard_ctrl #(
    parameter int NSRC     = 3,
    parameter int DEPTH    = 2,
    parameter int REGW     = 5,
    parameter int ZREG     = 31,
    parameter int LOAD_LAT = 1,
    localparam int SELW    = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [REGW-1:0]        id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic [NSRC*REGW-1:0]   id_src,
    input  logic [NSRC-1:0]        id_src_used,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   fwd_sel
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]            fwd_count,
    output logic [31:0]            stall_count
`endif
);

    localparam logic [REGW-1:0] ZREG_IDX = REGW'(ZREG);

    // Scoreboard state
    logic [DEPTH-1:0]           e_vld_q, e_vld_d;
    logic [DEPTH-1:0]           e_rw_q,  e_rw_d;
    logic [DEPTH-1:0]           e_ld_q,  e_ld_d;
    logic [DEPTH-1:0][REGW-1:0] e_rd_q,  e_rd_d;
    logic [NSRC*SELW-1:0]       fwd_sel_q, fwd_sel_d;

    // Hazard / select evaluation for the instruction in ID
    logic [NSRC*SELW-1:0]       sel_calc;
    logic                       hazard;
    logic [REGW-1:0]            src_idx;
    logic                       src_haz;
    logic [SELW-1:0]            src_sel;

    always_comb begin
        hazard   = 1'b0;
        sel_calc = '0;
        src_idx  = '0;
        src_haz  = 1'b0;
        src_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_idx = id_src[i*REGW +: REGW];
            src_haz = 1'b0;
            src_sel = '0;
            // Walk oldest to youngest so the youngest match overwrites.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (id_valid && id_src_used[i] && (src_idx != ZREG_IDX) &&
                    e_vld_q[j] && e_rw_q[j] && (e_rd_q[j] == src_idx)) begin
                    if (e_ld_q[j] && (j < LOAD_LAT)) begin
                        // Load data not available yet in that stage.
                        src_haz = 1'b1;
                        src_sel = '0;
                    end else begin
                        src_haz = 1'b0;
                        src_sel = SELW'(j + 1);
                    end
                end
            end
            hazard                      = hazard | src_haz;
            sel_calc[i*SELW +: SELW]    = src_sel;
        end
    end

    assign stall = hazard && !flush && !hold;

    // Next-state: shift the scoreboard unless frozen. A flushed or stalled
    // ID instruction enters EX as a bubble with no bypass selected.
    always_comb begin
        e_vld_d   = e_vld_q;
        e_rw_d    = e_rw_q;
        e_ld_d    = e_ld_q;
        e_rd_d    = e_rd_q;
        fwd_sel_d = fwd_sel_q;
        if (!hold) begin
            for (int j = 1; j < DEPTH; j++) begin
                e_vld_d[j] = e_vld_q[j-1];
                e_rw_d[j]  = e_rw_q[j-1];
                e_ld_d[j]  = e_ld_q[j-1];
                e_rd_d[j]  = e_rd_q[j-1];
            end
            if (flush || stall) begin
                e_vld_d[0] = 1'b0;
                e_rw_d[0]  = 1'b0;
                e_ld_d[0]  = 1'b0;
                e_rd_d[0]  = '0;
                fwd_sel_d  = '0;
            end else begin
                e_vld_d[0] = id_valid;
                e_rw_d[0]  = id_regwrite;
                e_ld_d[0]  = id_is_load;
                e_rd_d[0]  = id_rd;
                fwd_sel_d  = sel_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld_q   <= '0;
            e_rw_q    <= '0;
            e_ld_q    <= '0;
            fwd_sel_q <= '0;
        end else begin
            e_vld_q   <= e_vld_d;
            e_rw_q    <= e_rw_d;
            e_ld_q    <= e_ld_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    // Destination indices are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        e_rd_q <= e_rd_d;
    end

    assign fwd_sel = fwd_sel_q;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_count_q, stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            // Count instructions that issue into EX with any bypass active.
            if (!hold && !flush && !stall && (|sel_calc)) begin
                fwd_count_q <= fwd_count_q + 32'd1;
            end
            if (stall) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. dut1 uses the default parameters.
// dut2 uses DEPTH=3, LOAD_LAT=2. Both duts share the same stimulus.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset, hold, flush;
    logic        id_valid, id_regwrite, id_is_load;
    logic [4:0]  id_rd;
    logic [14:0] id_src;
    logic [2:0]  id_src_used;
    logic        stall1, stall2;
    logic [5:0]  sel1, sel2;
`ifdef FWD_STATS_EN
    logic [31:0] fcnt1, scnt1, fcnt2, scnt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut1 (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_src(id_src), .id_src_used(id_src_used),
        .stall(stall1), .fwd_sel(sel1)
`ifdef FWD_STATS_EN
        , .fwd_count(fcnt1), .stall_count(scnt1)
`endif
    );

    fwd_hazard_ctrl #(.DEPTH(3), .LOAD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_src(id_src), .id_src_used(id_src_used),
        .stall(stall2), .fwd_sel(sel2)
`ifdef FWD_STATS_EN
        , .fwd_count(fcnt2), .stall_count(scnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] used);
        id_valid    = v;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_src      = {s2, s1, s0};
        id_src_used = used;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_sel", 32'(sel1), 0);
        chk("reset_stall", 32'(stall1), 0);

        // ADD X1 ; ADD X2,X1,X3 -> fwd_sel[0] = 1
        drive(1, 1, 1, 0, 2, 3, 0, 3'b011); #1;
        chk("add1_stall", 32'(stall1), 0);
        tick();
        chk("add1_sel", 32'(sel1), 0);
        drive(1, 2, 1, 0, 1, 3, 0, 3'b011); #1;
        chk("dep_stall", 32'(stall1), 0);
        tick();
        chk("dep_sel_exmem", 32'(sel1), 6'b000001);

        // ADD X1 ; NOP ; SUB X4,X5,X1 -> fwd_sel[1] = 2
        drive(1, 1, 1, 0, 5, 6, 0, 3'b011); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000); tick();
        drive(1, 4, 1, 0, 5, 1, 0, 3'b011); #1;
        chk("memwb_stall", 32'(stall1), 0);
        tick();
        chk("memwb_sel", 32'(sel1), 6'b001000);

        // ADD X1 ; ADD X1 ; ORR X6,X1,X1 -> youngest wins, both 1
        drive(1, 1, 1, 0, 0, 0, 0, 3'b000); tick();
        drive(1, 1, 1, 0, 7, 8, 0, 3'b011); tick();
        drive(1, 6, 1, 0, 1, 1, 0, 3'b011); tick();
        chk("youngest_sel", 32'(sel1), 6'b000101);

        // LDUR X9 ; ADD X2,X9,X9 -> 1 stall, bubble, then sel 2/2
        drive(1, 9, 1, 1, 10, 0, 0, 3'b001); tick();
        drive(1, 2, 1, 0, 9, 9, 0, 3'b011); #1;
        chk("lu_stall", 32'(stall1), 1);
        tick();
        chk("lu_bubble_sel", 32'(sel1), 0);
        chk("lu_stall_done", 32'(stall1), 0);
        tick();
        chk("lu_sel", 32'(sel1), 6'b001010);

        // Writes to X31 and non-writing producers never forward
        drive(1, 31, 1, 0, 0, 0, 0, 3'b000); tick();
        drive(1, 12, 0, 0, 31, 31, 0, 3'b011); #1;
        chk("zreg_stall", 32'(stall1), 0);
        tick();
        chk("zreg_sel", 32'(sel1), 0);
        drive(1, 13, 1, 0, 12, 12, 0, 3'b011); tick();
        chk("norw_sel", 32'(sel1), 0);

        // ADD X7 ; STUR X7,[X8] -> store-data slot 2 forwarded
        drive(1, 7, 1, 0, 0, 0, 0, 3'b000); tick();
        drive(1, 0, 0, 0, 8, 0, 7, 3'b101); #1;
        chk("stur_stall", 32'(stall1), 0);
        tick();
        chk("stur_sel", 32'(sel1), 6'b010000);

        // LDUR X9,[X7] forwards from MEM/WB; then load-use under hold
        drive(1, 9, 1, 1, 7, 0, 0, 3'b001); tick();
        chk("ldur_base_sel", 32'(sel1), 6'b000010);
        drive(1, 3, 1, 0, 9, 0, 0, 3'b001); #1;
        chk("pre_hold_stall", 32'(stall1), 1);
        hold = 1'b1; #1;
        chk("hold_stall", 32'(stall1), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_frozen_stall", 32'(stall1), 0);
            chk("hold_frozen_sel", 32'(sel1), 6'b000010);
        end
        hold = 1'b0; #1;
        chk("resume_stall", 32'(stall1), 1);
        tick();
        chk("resume_bubble_sel", 32'(sel1), 0);
        chk("resume_stall_done", 32'(stall1), 0);
        tick();
        chk("resume_sel", 32'(sel1), 6'b000010);

        // Flush in the hazard cycle suppresses stall and selects
        drive(1, 9, 1, 1, 0, 0, 0, 3'b000); tick();
        drive(1, 3, 1, 0, 9, 0, 0, 3'b001);
        flush = 1'b1; #1;
        chk("flush_stall", 32'(stall1), 0);
        tick();
        flush = 1'b0;
        chk("flush_sel", 32'(sel1), 0);

        // dut2: LOAD_LAT=2, DEPTH=3 -> two stall cycles, then sel 3
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000); tick();
        reset = 1'b0;
        drive(1, 9, 1, 1, 0, 0, 0, 3'b000); tick();
        drive(1, 2, 1, 0, 9, 9, 0, 3'b011); #1;
        chk("lat2_stall_a", 32'(stall2), 1);
        tick();
        chk("lat2_bubble_a", 32'(sel2), 0);
        chk("lat2_stall_b", 32'(stall2), 1);
        tick();
        chk("lat2_bubble_b", 32'(sel2), 0);
        chk("lat2_stall_done", 32'(stall2), 0);
        tick();
        chk("lat2_sel", 32'(sel2), 6'b001111);

        // dut2: reset in the middle of a two-cycle stall
        drive(1, 9, 1, 1, 0, 0, 0, 3'b000); tick();
        drive(1, 2, 1, 0, 9, 9, 0, 3'b011); #1;
        chk("rst_mid_stall_a", 32'(stall2), 1);
        tick();
        chk("rst_mid_stall_b", 32'(stall2), 1);
        reset = 1'b1; tick();
        reset = 1'b0; #1;
        chk("rst_mid_stall_cleared", 32'(stall2), 0);
        chk("rst_mid_sel", 32'(sel2), 0);
        chk("rst_mid_stall1", 32'(stall1), 0);
        tick();
        chk("rst_mid_sel_next", 32'(sel2), 0);

`ifdef FWD_STATS_EN
        // 3 forwarding ADDs plus a load-use whose consumer forwards
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000); tick();
        reset = 1'b0;
        drive(1, 1, 1, 0, 0, 0, 0, 3'b000); tick();
        drive(1, 2, 1, 0, 1, 0, 0, 3'b001); tick();
        drive(1, 3, 1, 0, 2, 0, 0, 3'b001); tick();
        drive(1, 4, 1, 0, 3, 0, 0, 3'b001); tick();
        drive(1, 9, 1, 1, 0, 0, 0, 3'b000); tick();
        drive(1, 5, 1, 0, 9, 0, 0, 3'b001); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000); tick();
        chk("stats_fwd", fcnt1, 4);
        chk("stats_stall", scnt1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
